// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding control for the 5-stage RV32 pipe: comb stall/flush/freeze, fwd selects registered (1 cycle).
// mem_busy freezes shadows, selects and FSM; a taken branch overrides a pending load-use stall.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              freeze
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } shadow_t;

  typedef enum logic [1:0] {RUN, LU_STALL, HOLD} state_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  state_t  state_q, state_d;
  state_t  resume_q, resume_d;
  state_t  eff_state;
  shadow_t ex_q, mem_q, id_info;
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic    lu_hazard;

  // Newest producer wins; a load in EX is never an ALU source, so it falls through to MEM.
  function automatic logic [1:0] pick_sel(input logic use_rs, input logic [REG_AW-1:0] rs,
                                          input shadow_t ex_s, input shadow_t mem_s);
    logic [1:0] sel;
    sel = SEL_REG;
    if (use_rs && rs != '0) begin
      if (ex_s.valid && ex_s.regwrite && !ex_s.memread && ex_s.rd == rs)
        sel = SEL_ALU;
      else if (mem_s.valid && mem_s.regwrite && mem_s.rd == rs)
        sel = SEL_WB;
    end
    return sel;
  endfunction

  assign id_info = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  assign lu_hazard = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                     ((id_use_rs1 && id_rs1 == ex_q.rd) || (id_use_rs2 && id_rs2 == ex_q.rd));

  assign eff_state = (state_q == HOLD) ? resume_q : state_q;

  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        freeze   = 1'b1;
        state_d  = HOLD;
        resume_d = eff_state;
      end else if (ex_branch_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = RUN;
        fwd_a_d   = SEL_REG;
        fwd_b_d   = SEL_REG;
      end else if (lu_hazard) begin
        // Same rule from RUN or LU_STALL: back-to-back loads can chain stalls.
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = LU_STALL;
        fwd_a_d   = SEL_REG;
        fwd_b_d   = SEL_REG;
      end else begin
        state_d = RUN;
        if (id_valid) begin
          fwd_a_d = pick_sel(id_use_rs1, id_rs1, ex_q, mem_q);
          fwd_b_d = pick_sel(id_use_rs2, id_rs2, ex_q, mem_q);
        end else begin
          fwd_a_d = SEL_REG;
          fwd_b_d = SEL_REG;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      resume_q <= RUN;
      ex_q     <= '0;
      mem_q    <= '0;
      fwd_a_q  <= SEL_REG;
      fwd_b_q  <= SEL_REG;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      if (!mem_busy) begin
        mem_q <= ex_q;
        ex_q  <= bubble_ex ? '0 : id_info;
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed vector table for the pipeline scenarios, then random traffic against a stage-list model.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic       ex_branch_taken, mem_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if, stall_id, bubble_ex, flush_id, freeze;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id), .freeze(freeze)
  );

  typedef struct {
    bit       rst, busy, br, vld;
    bit [4:0] rs1, rs2;
    bit       u1, u2;
    bit [4:0] rd;
    bit       rw, ld;
  } in_t;

  typedef struct {
    in_t      in;
    bit [8:0] exp;  // {fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_id, freeze}
  } vec_t;

  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       rw, ld;
  } instr_t;

  // Model: pipe[0] is the instruction in EX, pipe[1] the one in MEM.
  instr_t   pipe[2];
  bit [1:0] m_sel_a, m_sel_b;

  function automatic vec_t mk(input bit rst_i, busy, br, vld, input bit [4:0] rs1, rs2,
                              input bit u1, u2, input bit [4:0] rd, input bit rw, ld,
                              input bit [8:0] exp);
    vec_t v;
    v.in = '{rst: rst_i, busy: busy, br: br, vld: vld, rs1: rs1, rs2: rs2,
             u1: u1, u2: u2, rd: rd, rw: rw, ld: ld};
    v.exp = exp;
    return v;
  endfunction

  function automatic bit [1:0] src_sel(input bit use_rs, input bit [4:0] rs);
    if (!use_rs || rs == 0) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].valid && pipe[k].rw && pipe[k].rd == rs && !(k == 0 && pipe[k].ld))
        return (k == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit load_use(input in_t x);
    return x.vld && pipe[0].valid && pipe[0].ld && pipe[0].rd != 0 &&
           ((x.u1 && x.rs1 == pipe[0].rd) || (x.u2 && x.rs2 == pipe[0].rd));
  endfunction

  function automatic bit [8:0] model_out(input in_t x);
    bit lu, stl, bub, fl, frz;
    lu  = load_use(x);
    frz = !x.rst && x.busy;
    fl  = !x.rst && !x.busy && x.br;
    bub = !x.rst && !x.busy && (x.br || lu);
    stl = !x.rst && !x.busy && !x.br && lu;
    return {m_sel_a, m_sel_b, stl, stl, bub, fl, frz};
  endfunction

  task automatic model_edge(input in_t x);
    bit kill;
    if (x.rst) begin
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};
      m_sel_a = 0;
      m_sel_b = 0;
    end else if (!x.busy) begin
      kill = x.br || load_use(x);
      m_sel_a = (kill || !x.vld) ? 2'b00 : src_sel(x.u1, x.rs1);
      m_sel_b = (kill || !x.vld) ? 2'b00 : src_sel(x.u2, x.rs2);
      pipe[1] = pipe[0];
      pipe[0] = kill ? '{default: 0} : '{valid: x.vld, rd: x.rd, rw: x.rw, ld: x.ld};
    end
  endtask

  task automatic apply(input in_t x, input bit use_exp, input bit [8:0] exp, input string name);
    bit [8:0] act, want;
    rst = x.rst; mem_busy = x.busy; ex_branch_taken = x.br; id_valid = x.vld;
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_use_rs1 = x.u1; id_use_rs2 = x.u2;
    id_rd = x.rd; id_regwrite = x.rw; id_memread = x.ld;
    @(negedge clk);
    act  = {fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex, flush_id, freeze};
    want = use_exp ? exp : model_out(x);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (fa fb si sd bx fl fz)", name, act, want);
    end
    model_edge(x);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[30];
  in_t  r;

  initial begin
    // rst busy br vld rs1 rs2 u1 u2 rd rw ld expected
    tbl[0]  = mk(1,0,0,0, 0,0, 0,0, 0,0,0, 9'b00_00_00000); // reset state
    tbl[1]  = mk(0,0,0,1, 1,2, 1,1, 5,1,0, 9'b00_00_00000); // add x5
    tbl[2]  = mk(0,0,0,1, 5,1, 1,1, 6,1,0, 9'b00_00_00000); // sub x6,x5,x1
    tbl[3]  = mk(0,0,0,0, 0,0, 0,0, 0,0,0, 9'b10_00_00000); // sub in EX: A from ALU
    tbl[4]  = mk(0,0,0,1, 1,2, 1,1, 5,1,0, 9'b00_00_00000); // add x5
    tbl[5]  = mk(0,0,0,0, 0,0, 0,0, 0,0,0, 9'b00_00_00000); // nop
    tbl[6]  = mk(0,0,0,1, 5,0, 1,1, 9,1,0, 9'b00_00_00000); // or x9,x5,x0
    tbl[7]  = mk(0,0,0,1, 1,2, 1,1, 0,1,0, 9'b01_00_00000); // or in EX: A from WB, B x0
    tbl[8]  = mk(0,0,0,1, 0,0, 1,1, 3,1,0, 9'b00_00_00000); // reads x0 after x0 writer
    tbl[9]  = mk(0,0,0,0, 0,0, 0,0, 0,0,0, 9'b00_00_00000); // x0 never forwarded
    tbl[10] = mk(0,0,0,1, 1,0, 1,0, 7,1,1, 9'b00_00_00000); // lw x7
    tbl[11] = mk(0,0,0,1, 7,7, 1,1, 8,1,0, 9'b00_00_11100); // add x8,x7,x7 stalls
    tbl[12] = mk(0,0,0,1, 7,7, 1,1, 8,1,0, 9'b00_00_00000); // re-presented, no stall
    tbl[13] = mk(0,0,0,0, 0,0, 0,0, 0,0,0, 9'b01_01_00000); // add in EX: both from WB
    tbl[14] = mk(0,0,0,1, 1,0, 1,0, 7,1,1, 9'b00_00_00000); // lw x7
    tbl[15] = mk(0,0,1,1, 7,7, 1,1, 8,1,0, 9'b00_00_00110); // load-use + branch
    tbl[16] = mk(0,0,0,0, 0,0, 0,0, 0,0,0, 9'b00_00_00000); // selects 00 after flush
    tbl[17] = mk(0,0,0,1, 1,0, 1,0, 7,1,1, 9'b00_00_00000); // lw x7
    tbl[18] = mk(0,0,0,1, 7,7, 1,1, 8,1,0, 9'b00_00_11100); // stall
    tbl[19] = mk(0,1,0,1, 7,7, 1,1, 8,1,0, 9'b00_00_00001); // freeze in LU_STALL
    tbl[20] = mk(0,1,0,1, 7,7, 1,1, 8,1,0, 9'b00_00_00001);
    tbl[21] = mk(0,1,0,1, 7,7, 1,1, 8,1,0, 9'b00_00_00001);
    tbl[22] = mk(0,0,0,1, 7,7, 1,1, 8,1,0, 9'b00_00_00000); // release, no extra stall
    tbl[23] = mk(0,0,0,0, 0,0, 0,0, 0,0,0, 9'b01_01_00000);
    tbl[24] = mk(0,0,0,1, 1,2, 1,1, 5,1,0, 9'b00_00_00000); // add x5
    tbl[25] = mk(0,0,0,1, 5,1, 1,1, 6,1,0, 9'b00_00_00000); // sub x6,x5,x1
    tbl[26] = mk(0,1,0,1, 6,5, 1,1, 9,1,0, 9'b10_00_00001); // HOLD, sel held
    tbl[27] = mk(1,1,0,1, 6,5, 1,1, 9,1,0, 9'b10_00_00000); // rst during HOLD
    tbl[28] = mk(0,0,0,1, 6,5, 1,1, 9,1,0, 9'b00_00_00000); // all cleared
    tbl[29] = mk(0,0,0,0, 0,0, 0,0, 0,0,0, 9'b00_00_00000); // shadows were cleared

    r = '{rst: 1, default: 0};
    rst = 1; mem_busy = 0; ex_branch_taken = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_memread = 0;
    repeat (2) @(posedge clk);
    #1;
    model_edge(r);

    for (int i = 0; i < 30; i++)
      apply(tbl[i].in, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 3000; i++) begin
      r.rst  = ($urandom_range(0, 99) < 2);
      r.busy = ($urandom_range(0, 99) < 15);
      r.br   = ($urandom_range(0, 99) < 10);
      r.vld  = ($urandom_range(0, 99) < 85);
      r.rs1  = 5'($urandom_range(0, 3));
      r.rs2  = 5'($urandom_range(0, 3));
      r.u1   = ($urandom_range(0, 99) < 80);
      r.u2   = ($urandom_range(0, 99) < 60);
      r.rd   = 5'($urandom_range(0, 3));
      r.ld   = ($urandom_range(0, 99) < 30);
      r.rw   = r.ld || ($urandom_range(0, 99) < 75);
      apply(r, 1'b0, 9'b0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
